display_arbiter: RTL

Time-shares the six-digit seven-segment display between up to four requesters: the shift-strobe counter, the FSM output counters, the rotary-encoder readout and any future status source. Grants are round-robin with a minimum hold time counted in slow strobe pulses, so each source stays readable before the display moves on. The block sits between the per-source counters and the `seven_segment_digit` instances. It replaces the hard switch-driven source mux.

---
 rtl/display_arbiter_if.sv | 45 ++++
 rtl/display_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/display_arbiter_if.sv
// display_arbiter_if
//   Bundle between the per-source display counters and the display arbiter.
//   The requester side (master) drives the strobe, the request levels, the
//   source words and the rotation lock. The arbiter side (slave) returns the
//   one-hot grant, the owner index, the busy flag, the registered display
//   word and the grant-change pulse.
//
//   Parameters
//     n_req : number of requesters (2..4)
//     w     : display word width, one nibble per digit
//
//   Signals
//     en           : one-cycle time strobe
//     req          : per-source request, level sensitive
//     data         : source words, source i at [i*w +: w]
//     lock         : freezes rotation (does not block release)
//     grant        : one-hot owner, or all zero
//     owner        : owner index, meaningful only while busy
//     busy         : some source is granted
//     number       : registered word of the current owner
//     switch_pulse : one-cycle flag on every grant change
interface display_arbiter_if #(
  parameter int n_req = 4,
  parameter int w     = 24
);
  logic                 en;
  logic [n_req-1:0]     req;
  logic [n_req*w-1:0]   data;
  logic                 lock;
  logic [n_req-1:0]     grant;
  logic [1:0]           owner;
  logic                 busy;
  logic [w-1:0]         number;
  logic                 switch_pulse;

  modport master (
    output en, req, data, lock,
    input  grant, owner, busy, number, switch_pulse
  );

  modport slave (
    input  en, req, data, lock,
    output grant, owner, busy, number, switch_pulse
  );
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter
//   Time-shares the six-digit seven-segment display between up to four
//   sources. Grants are round-robin; once a source owns the display it keeps
//   it for a minimum number of slow strobes before rotation is allowed, so
//   the readout stays legible. A source that drops its request releases the
//   display immediately, regardless of lock, strobe or hold count.
//
//   Parameters
//     n_req      : number of requesters, legal 2..4
//     w          : display word width
//     hold_width : width of the hold counter
//     hold_min   : strobes an owner keeps the display before it may rotate,
//                  must be below 2**hold_width
//
//   Ports
//     clk     : clock, rising edge
//     reset_n : asynchronous reset, active low; clears every output at once
//     bus     : slave side of display_arbiter_if (en, req, data, lock in;
//               grant, owner, busy, number, switch_pulse out)
//
//   switch_pulse is raised for one cycle whenever the grant vector changes,
//   including a release that leaves the display idle.
module display_arbiter #(
  parameter int n_req      = 4,
  parameter int w          = 24,
  parameter int hold_width = 4,
  parameter int hold_min   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  display_arbiter_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [n_req-1:0]       grant_reg;
  logic [1:0]             owner_reg;
  logic [1:0]             last_reg;
  logic                   busy_reg;
  logic                   switch_pulse_reg;
  logic [w-1:0]           number_reg;
  logic [hold_width-1:0]  hold_reg;

  // Source words split out of the flat data bus.
  logic [w-1:0] words [n_req];

  generate
    for (genvar gi = 0; gi < n_req; gi++) begin : g_word
      assign words[gi] = bus.data[gi*w +: w];
    end
  endgenerate

  logic             any_req;
  logic             owner_req;
  logic             other_req;
  logic             hold_full;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [n_req-1:0] win_onehot;
  logic             take_grant;
  logic             go_idle;

  assign any_req    = |bus.req;
  assign owner_req  = |(bus.req & grant_reg);
  assign other_req  = |(bus.req & ~grant_reg);
  assign hold_full  = (hold_reg == hold_width'(hold_min));
  assign win_onehot = n_req'(1) << win_idx;

  // Cyclic scan starting just after the last owner. Because last always
  // equals the current owner while one exists, the owner is visited last
  // and therefore only wins when it is the sole requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= n_req; off++) begin
      cand = 2'((int'(last_reg) + off) % n_req);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Decision for this edge. Release is evaluated before rotation, so a
  // dropped request always moves the display even while locked.
  always_comb begin
    take_grant = 1'b0;
    go_idle    = 1'b0;
    unique case (state_reg)
      IDLE: take_grant = any_req;
      OWN: begin
        if (!owner_req) begin
          take_grant = any_req;
          go_idle    = !any_req;
        end else if (bus.en && hold_full && !bus.lock && other_req) begin
          take_grant = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      owner_reg        <= '0;
      last_reg         <= 2'(n_req - 1);
      busy_reg         <= 1'b0;
      switch_pulse_reg <= 1'b0;
      number_reg       <= '0;
      hold_reg         <= '0;
    end else begin
      switch_pulse_reg <= 1'b0;
      if (take_grant) begin
        // win_found is implied: take_grant needs at least one other request.
        state_reg        <= OWN;
        grant_reg        <= win_onehot;
        owner_reg        <= win_idx;
        last_reg         <= win_idx;
        busy_reg         <= 1'b1;
        number_reg       <= words[win_idx];
        hold_reg         <= '0;
        switch_pulse_reg <= 1'b1;
      end else if (go_idle) begin
        state_reg        <= IDLE;
        grant_reg        <= '0;
        busy_reg         <= 1'b0;
        number_reg       <= '0;
        hold_reg         <= '0;
        switch_pulse_reg <= 1'b1;
      end else if (state_reg == OWN) begin
        // Holding: count strobes up to hold_min and keep following the
        // owner's live word.
        if (bus.en && !hold_full) begin
          hold_reg <= hold_reg + hold_width'(1);
        end
        number_reg <= words[owner_reg];
      end else begin
        number_reg <= '0;
      end
    end
  end

  assign bus.grant        = grant_reg;
  assign bus.owner        = owner_reg;
  assign bus.busy         = busy_reg;
  assign bus.number       = number_reg;
  assign bus.switch_pulse = switch_pulse_reg;

endmodule
